// File: rtl/display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter_if
//  Description : Bundles the requester-side bus of the display arbiter.
//                The master modport is the requester/driver side (drives
//                clear, req and data0..2, observes the display outputs).
//                The slave modport is the arbiter itself.
//                Ports carried:
//                  clear        - blank display and drop ownership
//                  req[2:0]     - level-sensitive per-requester requests
//                  data0..data2 - 8-digit BCD values offered by requesters
//                  ack[2:0]     - one-hot "data_i was loaded" pulse
//                  num[31:0]    - value driven to the seven-segment driver
//                  on_off       - display enable
//                  owner[1:0]   - current/last owner, 2'b11 = none
//                  busy         - arbiter is holding a grant
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_arbiter_if;
  logic        clear;
  logic [2:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  ack;
  logic [31:0] num;
  logic        on_off;
  logic [1:0]  owner;
  logic        busy;

  modport master (
    output clear, req, data0, data1, data2,
    input  ack, num, on_off, owner, busy
  );

  modport slave (
    input  clear, req, data0, data1, data2,
    output ack, num, on_off, owner, busy
  );
endinterface
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter
//  Description : Round-robin arbiter granting one of three requesters
//                ownership of a seven-segment display for at least
//                HOLD_CYCLES clock cycles. While holding, the owner may
//                refresh the displayed value; others wait at the input.
//                Ports:
//                  clk  - system clock, rising edge
//                  rst  - synchronous active-high reset
//                  bus  - display_arbiter_if.slave (see interface header)
//                Parameter:
//                  HOLD_CYCLES - minimum ownership length in cycles (>=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 32'd50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  display_arbiter_if.slave      bus
);

  // Counter is loaded with HOLD_CYCLES-1 so that a grant occupies exactly
  // HOLD_CYCLES HOLD cycles, the last one being the cycle where it reads 0.
  localparam logic [31:0] C_RELOAD = 32'(HOLD_CYCLES - 32'd1);
  localparam logic [1:0]  C_NO_OWNER = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      state_q,  state_d;
  logic [31:0] cnt_q,    cnt_d;
  logic [31:0] num_q,    num_d;
  logic [2:0]  ack_q,    ack_d;
  logic [1:0]  owner_q,  owner_d;
  logic        on_off_q, on_off_d;
  logic        busy_q,   busy_d;

  // Round-robin pick: search starts just after the last owner so that the
  // last owner ranks lowest. Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] r,
                                         input logic [1:0] last);
    logic [1:0] o0, o1, o2;
    logic [2:0] res;
    case (last)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (r[o0])      res = {1'b1, o0};
    else if (r[o1]) res = {1'b1, o1};
    else if (r[o2]) res = {1'b1, o2};
    else            res = 3'b000;
    return res;
  endfunction

  function automatic logic [31:0] sel_data(input logic [1:0] idx,
                                           input logic [31:0] d0,
                                           input logic [31:0] d1,
                                           input logic [31:0] d2);
    logic [31:0] v;
    case (idx)
      2'd0:    v = d0;
      2'd1:    v = d1;
      2'd2:    v = d2;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  logic [2:0] pick;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic       owner_req;
  logic       do_grant;

  assign pick       = rr_pick(bus.req, owner_q);
  assign pick_found = pick[2];
  assign pick_idx   = pick[1:0];

  always_comb begin
    case (owner_q)
      2'd0:    owner_req = bus.req[0];
      2'd1:    owner_req = bus.req[1];
      2'd2:    owner_req = bus.req[2];
      default: owner_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    ack_d    = 3'b000;
    owner_d  = owner_q;
    on_off_d = on_off_q;
    do_grant = 1'b0;

    if (bus.clear) begin
      // clear wins over any request or expiry in the same cycle
      state_d  = ST_IDLE;
      cnt_d    = 32'h0;
      num_d    = 32'h0;
      on_off_d = 1'b0;
      owner_d  = C_NO_OWNER;
    end else begin
      case (state_q)
        ST_IDLE: begin
          do_grant = pick_found;
        end
        ST_HOLD: begin
          if (cnt_q != 32'h0) begin
            cnt_d = cnt_q - 32'd1;
            // Owner may refresh its value; the hold window is not extended.
            if (owner_req) begin
              num_d = sel_data(owner_q, bus.data0, bus.data1, bus.data2);
              ack_d = 3'b001 << owner_q;
            end
          end else if (pick_found) begin
            do_grant = 1'b1;
          end else begin
            // Nobody pending: keep showing the last value.
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (do_grant) begin
        state_d  = ST_HOLD;
        cnt_d    = C_RELOAD;
        num_d    = sel_data(pick_idx, bus.data0, bus.data1, bus.data2);
        ack_d    = 3'b001 << pick_idx;
        owner_d  = pick_idx;
        on_off_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 32'h0;
      num_q    <= 32'h0;
      ack_q    <= 3'b000;
      owner_q  <= C_NO_OWNER;
      on_off_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      ack_q    <= ack_d;
      owner_q  <= owner_d;
      on_off_q <= on_off_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.num    = num_q;
  assign bus.on_off = on_off_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_display_arbiter
//  Description : Self-checking bench for display_arbiter (HOLD_CYCLES=4).
//                A cycle-level reference model tracks ownership by the edge
//                number of the last grant; directed scenarios add literal
//                expectations, then a randomized phase runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

  localparam int HOLD = 4;

  logic clk;
  logic rst;

  display_arbiter_if bus ();

  display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int          edge_n = 0;
  int          m_grant_edge = 0;
  int          m_own = -1;       // -1 = no owner
  bit          m_hold = 0;
  bit          m_valid = 0;
  logic [31:0] m_num = 0;
  logic        m_on = 0;
  logic [2:0]  m_ack = 0;

  function automatic logic [31:0] dat(input int i);
    if (i == 0) return bus.data0;
    if (i == 1) return bus.data1;
    return bus.data2;
  endfunction

  always @(posedge clk) begin
    int w;
    edge_n++;
    m_ack = 3'b000;
    if (rst) begin
      m_valid = 1; m_hold = 0; m_own = -1; m_num = 0; m_on = 0;
    end else if (bus.clear) begin
      m_hold = 0; m_own = -1; m_num = 0; m_on = 0;
    end else if (m_hold && (edge_n - m_grant_edge) < HOLD) begin
      if (bus.req[m_own]) begin
        m_num = dat(m_own);
        m_ack = 3'(1 << m_own);
      end
    end else begin
      w = -1;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_own + k) % 3;
        if (w < 0 && bus.req[c]) w = c;
      end
      if (w >= 0) begin
        m_own = w; m_num = dat(w); m_ack = 3'(1 << w);
        m_on = 1; m_hold = 1; m_grant_edge = edge_n;
      end else begin
        m_hold = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [1:0] e_own;
    if (m_valid) begin
      e_own = (m_own < 0) ? 2'b11 : 2'(m_own);
      n_checks++;
      if (bus.num !== m_num || bus.ack !== m_ack || bus.owner !== e_own ||
          bus.on_off !== m_on || bus.busy !== m_hold) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got num=%h ack=%b owner=%0d on=%b busy=%b want num=%h ack=%b owner=%0d on=%b busy=%b",
                 $time, bus.num, bus.ack, bus.owner, bus.on_off, bus.busy,
                 m_num, m_ack, e_own, m_on, m_hold);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.clear = 1'b0; bus.req = 3'b000;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_num"},    bus.num,    32'h0);
    chk({tag, "_owner"},  32'(bus.owner),  32'd3);
    chk({tag, "_ack"},    32'(bus.ack),    32'd0);
    chk({tag, "_on_off"}, 32'(bus.on_off), 32'd0);
    chk({tag, "_busy"},   32'(bus.busy),   32'd0);
  endtask

  int seq [4] = '{0, 1, 2, 0};

  initial begin
    logic [31:0] tmp;
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.req   = 3'b000;
    bus.data0 = 32'h0000_0011;
    bus.data1 = 32'h0000_0022;
    bus.data2 = 32'h0000_0033;
    step(); step();
    chk_reset_vals("reset");

    // single request from requester 1
    rst = 1'b0;
    bus.req = 3'b010; bus.data1 = 32'h1234_5678;
    step();
    chk("r031_ack",   32'(bus.ack),    32'b010);
    chk("r031_num",   bus.num,         32'h1234_5678);
    chk("r031_owner", 32'(bus.owner),  32'd1);
    chk("r031_on",    32'(bus.on_off), 32'd1);
    chk("r031_busy",  32'(bus.busy),   32'd1);
    bus.req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r031_busy_hold", 32'(bus.busy), 32'd1);
    end
    step();
    chk("r031_busy_fall", 32'(bus.busy),  32'd0);
    chk("r031_keep_num",  bus.num,        32'h1234_5678);
    chk("r031_keep_own",  32'(bus.owner), 32'd1);

    // all three requesting: rotation 0,1,2,0
    do_reset();
    bus.req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("r032_owner", 32'(bus.owner), 32'(seq[g]));
      chk("r032_ack",   32'(bus.ack),   32'(1 << seq[g]));
      repeat (3) step();
    end

    // owner 0 refreshes while 2 waits
    do_reset();
    bus.req = 3'b001; bus.data0 = 32'h0000_0001; bus.data2 = 32'h2222_2222;
    step();
    chk("r033_grant0", 32'(bus.ack), 32'b001);
    bus.req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      tmp = $urandom;
      bus.data0 = tmp;
      step();
      chk("r033_track", bus.num, tmp);
      chk("r033_ack0",  32'(bus.ack), 32'b001);
    end
    step();
    chk("r033_owner2", 32'(bus.owner), 32'd2);
    chk("r033_ack2",   32'(bus.ack),   32'b100);
    chk("r033_num2",   bus.num,        32'h2222_2222);

    // clear and request together in IDLE
    do_reset();
    bus.clear = 1'b1; bus.req = 3'b001;
    step();
    chk_reset_vals("r034_clear");
    bus.clear = 1'b0;
    step();
    chk("r034_owner", 32'(bus.owner), 32'd0);
    chk("r034_ack",   32'(bus.ack),   32'b001);

    // reset in the middle of a hold
    do_reset();
    bus.req = 3'b011;
    step();
    step();
    rst = 1'b1;
    step();
    chk_reset_vals("r035_rst");
    rst = 1'b0;
    step();
    chk("r035_owner", 32'(bus.owner), 32'd0);
    chk("r035_ack",   32'(bus.ack),   32'b001);

    // single requester held across several expiries
    do_reset();
    bus.req = 3'b010;
    step();
    for (int i = 0; i < 13; i++) begin
      step();
      chk("r036_busy_owner", {29'h0, bus.busy, bus.owner}, 32'b101);
    end

    // randomized phase
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
      bus.clear = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      bus.data0 = $urandom;
      bus.data1 = $urandom;
      bus.data2 = $urandom;
      step();
    end
    rst = 1'b0; bus.clear = 1'b0; bus.req = 3'b000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000, SHALL set the minimum number of clk cycles a granted requester owns the display (legal range 1..2^32-1).
REQ-002 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 clear  input  1  SHALL, when high, blank the display and release ownership.
REQ-005 req  input  3  SHALL be per-requester display requests; bit i belongs to requester i, level-sensitive.
REQ-006 data0, data1, data2  input  32 each  SHALL be the 8-digit BCD value offered by requesters 0, 1, 2.
REQ-007 ack  output  3  SHALL be one-hot, registered; bit i high for exactly the cycles in which data_i was loaded into num.
REQ-008 num  output  32  SHALL be the registered value driven to the seven-segment display driver.
REQ-009 on_off  output  1  SHALL be the registered display enable for the display driver.
REQ-010 owner  output  2  SHALL be the index of the current or last owner; 2'b11 means none.
REQ-011 busy  output  1  SHALL be high while the FSM is in HOLD.

Function
REQ-012 FSM SHALL have exactly two states: IDLE (no owner holding) and HOLD (owner holding, hold counter running).
REQ-013 Arbitration SHALL be round-robin: search order starts at (owner+1) mod 3 and wraps, so the last owner ranks lowest; with owner=2'b11, order is 0,1,2.
REQ-014 IDLE with any req bit high SHALL, on the next edge, load num with the winner's data, pulse its ack bit, set owner, set on_off=1, load the hold counter with HOLD_CYCLES-1, and enter HOLD (request-to-display latency: 1 cycle).
REQ-015 IDLE with req=0 SHALL hold num, on_off, and owner unchanged, with ack=0.
REQ-016 HOLD with counter nonzero SHALL decrement the counter each cycle.
REQ-017 HOLD with counter nonzero and req[owner] high SHALL reload num from the owner's data and pulse ack[owner] without reloading the counter.
REQ-018 HOLD with counter nonzero SHALL ignore non-owner requests: no ack, and no state loss for them (they stay pending at the input).
REQ-019 HOLD with counter zero SHALL rearbitrate among all req bits using REQ-013.
REQ-020 At that rearbitration, a winner SHALL be loaded exactly as in REQ-014, remaining in HOLD; the previous owner can win only if no other requester is pending.
REQ-021 At that rearbitration, req=0 SHALL send the FSM to IDLE with num, owner, and on_off retained.
REQ-022 HOLD_CYCLES=1 SHALL give each grant exactly one HOLD cycle before the next rearbitration.
REQ-023 clear high SHALL, on the next edge, set num=0, on_off=0, ack=0, owner=2'b11, and counter=0, and enter IDLE.
REQ-024 clear SHALL override any simultaneous req or counter expiry; no ack is issued in that cycle.
REQ-025 ack SHALL never have more than one bit set, and SHALL never be set in a cycle in which num did not change source or value load.
REQ-026 The hold counter SHALL be 32 bits wide and SHALL never underflow; decrement occurs only when it is nonzero.

Reset
REQ-027 rst high at a clock edge SHALL set state=IDLE, num=32'h0, on_off=0, ack=3'b000, owner=2'b11, busy=0, and counter=0.
REQ-028 rst SHALL have priority over clear and req.
REQ-029 rst asserted mid-HOLD SHALL abandon the grant with no ack in that cycle.
REQ-030 Deasserting rst SHALL resume normal operation on the first following edge.

Verification (HOLD_CYCLES=4)
REQ-031 Reset, then req=3'b010 with data1=32'h12345678 for one cycle -> next cycle ack=3'b010, num=32'h12345678, owner=1, on_off=1, busy=1; busy falls 4 cycles later.
REQ-032 req=3'b111 held from IDLE after reset -> grants in order 0,1,2,0, each owner lasting 4 cycles, with exactly one ack bit per grant boundary.
REQ-033 Owner 0 held with data0 changing every cycle while req[2] is pending -> num tracks data0 for 4 cycles with ack[0] each cycle; then owner=2 and ack=3'b100.
REQ-034 clear and req=3'b001 asserted in the same IDLE cycle -> num=0, on_off=0, owner=2'b11, ack=0; the grant to 0 follows one cycle later if req persists.
REQ-035 rst pulsed during cycle 2 of HOLD with req=3'b011 -> all outputs at reset values next cycle; after rst drops, requester 0 is granted first.
REQ-036 Single requester 1 held continuously -> owner stays 1 across expiries; the counter reloads every 4 cycles with no IDLE gap.
